// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between NUM_REQ writeback
// sources (e.g. ALU, LSU, MULDIV). A round-robin arbiter grants at most one
// source per cycle. The granted result is registered and presented to the
// register file one cycle later. A busy scoreboard (one bit per architectural
// register) lets decode stall on RAW hazards and hold on WAW conflicts.
//
// Optional feature (compile-time macro WB_CONTENTION_EN):
//   defined   -> wb_contention_cnt counts cycles with >=2 valid requesters,
//                saturating at 16'hFFFF, cleared only by rst.
//   undefined -> no counter logic, wb_contention_cnt tied to 16'h0.
//
// Parameters
//   NUM_REQ     number of writeback requesters (2..8)
//   XLEN        data width
//   REG_ADDR_W  register address width (2**REG_ADDR_W registers)
//
// Ports
//   clk, rst           clock (posedge) / asynchronous active-high reset
//   req_valid/ready    per-requester handshake; transfer when valid & ready
//   req_rd, req_data   flat per-requester dest reg / result (slice i)
//   rf_w_en/rd/rdData  registered register-file write port
//   issue_valid/rd     decode issuing an instruction that writes issue_rd
//   issue_conflict     issue_rd already has a pending producer (WAW)
//   rs, rt             source registers being decoded
//   rs_busy, rt_busy   source has a pending producer -> decode stalls
//   wb_contention_cnt  contention statistics counter
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*XLEN-1:0]         req_data,
  output logic                            rf_w_en,
  output logic [REG_ADDR_W-1:0]           rf_rd,
  output logic [XLEN-1:0]                 rf_rdData,
  input  logic                            issue_valid,
  input  logic [REG_ADDR_W-1:0]           issue_rd,
  output logic                            issue_conflict,
  input  logic [REG_ADDR_W-1:0]           rs,
  input  logic [REG_ADDR_W-1:0]           rt,
  output logic                            rs_busy,
  output logic                            rt_busy,
  output logic [15:0]                     wb_contention_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << REG_ADDR_W;

  // Per-requester views of the flat request buses
  logic [REG_ADDR_W-1:0] w_rd   [NUM_REQ];
  logic [XLEN-1:0]       w_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_rd[g]   = req_rd[g*REG_ADDR_W +: REG_ADDR_W];
    assign w_data[g] = req_data[g*XLEN +: XLEN];
  end

  // State
  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_w_en;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;
  logic [NREG-1:0]       r_busy;

  // Arbitration
  logic                  w_gnt_found;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  int                    w_scan;

  // Walk requesters starting at r_rr_ptr, wrapping modulo NUM_REQ; the
  // first valid one wins. Selected rd/data are captured in the same walk so
  // no out-of-range index is ever formed for non power-of-two NUM_REQ.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    w_scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      if (!w_gnt_found && req_valid[w_scan]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = PTR_W'(w_scan);
        w_sel_rd    = w_rd[w_scan];
        w_sel_data  = w_data[w_scan];
      end
    end
  end

  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic               w_xfer;
  logic               w_wr;
  logic [PTR_W-1:0]   w_ptr_nxt;

  assign w_gnt_onehot = w_gnt_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
  // Ready is suppressed while reset is held; a result presented then is lost.
  assign req_ready    = rst ? '0 : w_gnt_onehot;
  assign w_xfer       = w_gnt_found && !rst;
  // rd==0 is accepted but never reaches the register file
  assign w_wr         = w_xfer && (w_sel_rd != '0);
  assign w_ptr_nxt    = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;

  // Scoreboard next state: clear on the write landing now, then set on
  // issue so a same-register set/clear collision leaves the bit busy.
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (r_w_en) w_busy_nxt[r_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_w_en   <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_busy   <= '0;
    end else begin
      r_w_en <= w_wr;
      if (w_wr) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
      end
      if (w_xfer) r_rr_ptr <= w_ptr_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign rf_w_en   = r_w_en;
  assign rf_rd     = r_rd;
  assign rf_rdData = r_data;

  // A register being written this cycle is already readable through the
  // register file's write-to-read bypass, so it is not reported busy.
  logic w_rs_wr, w_rt_wr, w_iss_wr;

  assign w_rs_wr  = r_w_en && (r_rd == rs);
  assign w_rt_wr  = r_w_en && (r_rd == rt);
  assign w_iss_wr = r_w_en && (r_rd == issue_rd);

  assign rs_busy        = (rs != '0) && r_busy[rs] && !w_rs_wr;
  assign rt_busy        = (rt != '0) && r_busy[rt] && !w_rt_wr;
  assign issue_conflict = issue_valid && (issue_rd != '0) && r_busy[issue_rd] && !w_iss_wr;

`ifdef WB_CONTENTION_EN
  // More than one bit set <=> clearing the lowest set bit leaves something.
  logic        w_multi;
  logic [15:0] r_cnt;

  assign w_multi = (req_valid & (req_valid - 1'b1)) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_multi && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign wb_contention_cnt = r_cnt;
`else
  assign wb_contention_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        rf_w_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_rdData;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_conflict;
  logic [4:0]  rs, rt;
  logic        rs_busy, rt_busy;
  logic [15:0] wb_contention_cnt;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_rdData(rf_rdData),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_conflict(issue_conflict),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .wb_contention_cnt(wb_contention_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges
  task automatic pulse_rst;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 3'b111;
    req_rd = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    rs = '0;
    rt = '0;

    // Reset state; ready must stay low even with every requester valid
    #3;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_wen",   rf_w_en, 1'b0);
    chk("rst_rd",    rf_rd, 5'd0);
    chk("rst_data",  rf_rdData, 32'h0);
    chk("rst_cnt",   wb_contention_cnt, 16'h0);
    tick;
    req_valid = 3'b000;
    rst = 1'b0;
    #1;

    // 1: single source, 1-cycle write latency
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    chk("t1_ready", req_ready, 3'b001);
    tick;
    req_valid = 3'b000;
    #1;
    chk("t1_wen",  rf_w_en, 1'b1);
    chk("t1_rd",   rf_rd, 5'd5);
    chk("t1_data", rf_rdData, 32'hDEADBEEF);
    tick;
    chk("t1_wen_off", rf_w_en, 1'b0);
    chk("t1_rd_hold", rf_rd, 5'd5);

    // 2: three valid for 6 cycles from reset -> 0,1,2,0,1,2
    pulse_rst;
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t2_ready", req_ready, 32'(1 << (c % 3)));
      if (c > 0) chk("t2_rd", rf_rd, 32'(((c - 1) % 3) + 1));
      tick;
    end
    req_valid = 3'b000;
    #1;
    chk("t2_rd_last",   rf_rd, 5'd3);
    chk("t2_data_last", rf_rdData, 32'hA2);
`ifdef WB_CONTENTION_EN
    chk("t2_cnt", wb_contention_cnt, 16'd6);
`else
    chk("t2_cnt", wb_contention_cnt, 16'd0);
`endif
    // pointer is 0: scan skips 0, grants 1
    req_valid = 3'b110;
    #1;
    chk("t2_skip", req_ready, 3'b010);
    tick;
    // pointer is 2: 2 idle, wraps to 0
    req_valid = 3'b011;
    #1;
    chk("t2_wrap", req_ready, 3'b001);
    tick;
    // pointer is 1: 1 idle, grants 2
    req_valid = 3'b101;
    #1;
    chk("t2_p1", req_ready, 3'b100);
    tick;
    req_valid = 3'b000;

    // 3: RAW scoreboard on rd=7
    pulse_rst;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    rs = 5'd7;
    rt = 5'd7;
    #1;
    chk("t3_c0_conf", issue_conflict, 1'b0);
    chk("t3_c0_rs",   rs_busy, 1'b0);
    tick;
    issue_valid = 1'b0;
    #1;
    chk("t3_c1_rs", rs_busy, 1'b1);
    chk("t3_c1_rt", rt_busy, 1'b1);
    tick;
    issue_valid = 1'b1;
    #1;
    chk("t3_c2_conf", issue_conflict, 1'b1);
    issue_valid = 1'b0;
    tick;
    set_req(1, 5'd7, 32'h77);
    req_valid = 3'b010;
    #1;
    chk("t3_c3_ready", req_ready, 3'b010);
    chk("t3_c3_rs",    rs_busy, 1'b1);
    tick;
    req_valid = 3'b000;
    #1;
    chk("t3_c4_wen", rf_w_en, 1'b1);
    chk("t3_c4_rd",  rf_rd, 5'd7);
    chk("t3_c4_rs",  rs_busy, 1'b0);
    chk("t3_c4_rt",  rt_busy, 1'b0);
    tick;
    chk("t3_c5_wen", rf_w_en, 1'b0);
    chk("t3_c5_rs",  rs_busy, 1'b0);

    // 4: set wins over clear on rd=9
    pulse_rst;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    tick;
    issue_valid = 1'b0;
    rs = 5'd9;
    set_req(2, 5'd9, 32'h99);
    req_valid = 3'b100;
    #1;
    chk("t4_busy", rs_busy, 1'b1);
    chk("t4_ready", req_ready, 3'b100);
    tick;
    req_valid = 3'b000;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    #1;
    chk("t4_wen",  rf_w_en, 1'b1);
    chk("t4_conf_wr", issue_conflict, 1'b0);
    chk("t4_rs_wr", rs_busy, 1'b0);
    tick;
    issue_valid = 1'b0;
    #1;
    chk("t4_set_wins", rs_busy, 1'b1);
    issue_valid = 1'b1;
    #1;
    chk("t4_conf", issue_conflict, 1'b1);
    issue_valid = 1'b0;

    // 5: rd=0 accepted, never written, never busy
    pulse_rst;
    set_req(1, 5'd0, 32'h1);
    req_valid = 3'b010;
    rs = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd0;
    #1;
    chk("t5_ready", req_ready, 3'b010);
    chk("t5_conf0", issue_conflict, 1'b0);
    tick;
    req_valid = 3'b000;
    issue_valid = 1'b0;
    #1;
    chk("t5_wen", rf_w_en, 1'b0);
    chk("t5_rs0", rs_busy, 1'b0);

    // 6: async reset mid-burst
    pulse_rst;
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    tick;
    issue_valid = 1'b0;
    set_req(0, 5'd4, 32'h44);
    set_req(1, 5'd5, 32'h55);
    set_req(2, 5'd6, 32'h66);
    req_valid = 3'b001;
    tick;
    req_valid = 3'b111;
    rs = 5'd3;
    #1;
    chk("t6_pre_wen", rf_w_en, 1'b1);
    chk("t6_pre_busy", rs_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_wen",   rf_w_en, 1'b0);
    chk("t6_rst_ready", req_ready, 3'b000);
    chk("t6_rst_busy",  rs_busy, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_restart", req_ready, 3'b001);
    tick;
    req_valid = 3'b000;
    #1;
    chk("t6_rd",   rf_rd, 5'd4);
    chk("t6_busy", rs_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
